// File: rtl/arbitro_mux_l1_pkg.sv
// Shared definitions for the layer-1 round-robin byte scheduler.
// Lane encoding and arbiter state types.
package arbitro_mux_l1_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

  // Pretend lane 1 went last so lane 0 wins the first tie.
  localparam last_t LAST_RST = LAST1;

endpackage

// File: rtl/arbitro_mux_l1_fifo.sv
// Per-lane byte FIFO with head-of-queue output.
// Full/empty decode straight from the registered count.
module fifo_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full  = (r_count == (ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arbitro_mux_l1.sv
// Work-conserving two-lane round-robin byte scheduler.
// One registered grant per clk_2f cycle into data_00.
module arbitro_mux_l1
  import arbitro_mux_l1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic                  valid_0,
  output logic                  full_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  valid_1,
  output logic                  full_1,
  input  logic                  pause_00,
  output logic [DATA_WIDTH-1:0] data_00,
  output logic                  valid_00,
  output logic                  lane_00,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] w_dout0;
  logic [DATA_WIDTH-1:0] w_dout1;
  logic [ADDR_WIDTH:0]   w_cnt0;
  logic [ADDR_WIDTH:0]   w_cnt1;
  logic w_full0, w_full1;
  logic w_empty0, w_empty1;
  logic w_ne0, w_ne1;
  logic w_push0, w_push1;
  logic w_pop0, w_pop1;
  logic w_gnt, w_lane;

  last_t                 r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_lane;
  logic                  r_ovf;

  assign w_ne0   = (w_cnt0 != '0);
  assign w_ne1   = (w_cnt1 != '0);
  assign w_push0 = valid_0 & ~w_full0;
  assign w_push1 = valid_1 & ~w_full1;
  assign w_pop0  = w_gnt & (w_lane == LANE_0) & ~w_empty0;
  assign w_pop1  = w_gnt & (w_lane == LANE_1) & ~w_empty1;

  fifo_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo0 (
    .clk  (clk_2f),
    .rst  (reset),
    .push (w_push0),
    .pop  (w_pop0),
    .din  (data_0),
    .dout (w_dout0),
    .full (w_full0),
    .empty(w_empty0),
    .count(w_cnt0)
  );

  fifo_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo1 (
    .clk  (clk_2f),
    .rst  (reset),
    .push (w_push1),
    .pop  (w_pop1),
    .din  (data_1),
    .dout (w_dout1),
    .full (w_full1),
    .empty(w_empty1),
    .count(w_cnt1)
  );

  always_comb begin
    w_gnt  = 1'b0;
    w_lane = LANE_0;
    if (!pause_00) begin
      unique case (1'b1)
        (w_ne0 & w_ne1): begin
          w_gnt  = 1'b1;
          w_lane = (r_last == LAST1) ? LANE_0 : LANE_1;
        end
        (w_ne0 & ~w_ne1): begin
          w_gnt  = 1'b1;
          w_lane = LANE_0;
        end
        (~w_ne0 & w_ne1): begin
          w_gnt  = 1'b1;
          w_lane = LANE_1;
        end
        default: begin
          w_gnt  = 1'b0;
          w_lane = LANE_0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_last  <= LAST_RST;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_lane  <= LANE_0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_data <= (w_lane == LANE_1) ? w_dout1 : w_dout0;
        r_lane <= w_lane;
        r_last <= last_t'(w_lane);
      end
      if ((valid_0 & w_full0) | (valid_1 & w_full1))
        r_ovf <= 1'b1;
    end
  end

  assign full_0   = w_full0;
  assign full_1   = w_full1;
  assign data_00  = r_data;
  assign valid_00 = r_valid;
  assign lane_00  = r_lane;
  assign overflow = r_ovf;

endmodule
